axi_lite_sram_slave: RTL and testbench

//  AXI-lite memory responder: the slave side of the lsu data-memory bus. Accepts one

---
 rtl/axi_lite_sram_slave.sv | 136 +++++++++++++
 tb/tb_axi_lite_sram_slave.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_sram_slave.sv
// AXI-lite word-array responder for the LSU data bus.
// One transaction in flight; programmable response latency.
module axi_lite_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT4  = 4'(LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        R_WAIT,
        R_RESP,
        W_WAIT,
        W_RESP
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic        ar_fire, aw_fire;
    logic        rd_load, wr_commit;
    logic [31:0] src_addr, src_wdata, off;
    logic [3:0]  src_wstrb;
    logic [IDX_W-1:0] idx;
    logic        hit;
    logic        unused;

    assign arready = rst && (state == IDLE);
    assign awready = rst && (state == IDLE)
                     && awvalid && wvalid && !arvalid;
    assign wready  = awready;
    assign ar_fire = arready && arvalid;
    assign aw_fire = awready;
    assign rvalid  = (state == R_RESP);
    assign bvalid  = (state == W_RESP);

    // With zero latency the response is loaded straight from the live bus
    assign src_addr  = (state == IDLE) ? (arvalid ? araddr : awaddr)
                                       : addr_q;
    assign src_wdata = (state == IDLE) ? wdata : wdata_q;
    assign src_wstrb = (state == IDLE) ? wstrb[3:0] : wstrb_q;

    assign off = src_addr - ADDR_BASE;
    assign idx = off[IDX_W+1:2];
    assign hit = (src_addr >= ADDR_BASE)
                 && ((off >> 2) < 32'(DEPTH_WORDS));
    assign unused = ^{wstrb[7:4], off[1:0]};

    assign rd_load   = (state_next == R_RESP) && (state != R_RESP);
    assign wr_commit = (state_next == W_RESP) && (state != W_RESP);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (ar_fire) begin
                    cnt_next   = 4'd0;
                    state_next = (LATENCY == 0) ? R_RESP : R_WAIT;
                end else if (aw_fire) begin
                    cnt_next   = 4'd0;
                    state_next = (LATENCY == 0) ? W_RESP : W_WAIT;
                end
            end
            R_WAIT: begin
                cnt_next = cnt + 4'd1;
                if (cnt_next == LAT4) state_next = R_RESP;
            end
            W_WAIT: begin
                cnt_next = cnt + 4'd1;
                if (cnt_next == LAT4) state_next = W_RESP;
            end
            R_RESP: if (rready) state_next = IDLE;
            W_RESP: if (bready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rdata <= 32'd0;
            rresp <= 2'b00;
            bresp <= 2'b00;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (ar_fire || aw_fire) addr_q <= src_addr;
            if (aw_fire) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb[3:0];
            end
            if (rd_load) begin
                rdata <= hit ? mem[idx] : 32'd0;
                rresp <= hit ? 2'b00 : 2'b10;
            end
            if (wr_commit) bresp <= hit ? 2'b00 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wr_commit && hit) begin
            for (int i = 0; i < 4; i++) begin
                if (src_wstrb[i]) mem[idx][8*i +: 8] <= src_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Scoreboard bench for axi_lite_sram_slave (LATENCY=2 main, LATENCY=0 side).
module tb_axi_lite_sram_slave;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          LAT  = 2;

    logic        clk = 0;
    logic        rst = 0;
    logic [31:0] araddr = 0, awaddr = 0, wdata = 0;
    logic [7:0]  wstrb = 0;
    logic        arvalid = 0, awvalid = 0, wvalid = 0;
    logic        rready = 1, bready = 1;

    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    logic        arready_z, rvalid_z, awready_z, wready_z, bvalid_z;
    logic [31:0] rdata_z;
    logic [1:0]  rresp_z, bresp_z;

    int n_err = 0;
    int n_checks = 0;

    logic [33:0] rq[$];
    logic [1:0]  bq[$];
    logic [31:0] mdl [1024];

    always #5 clk = ~clk;

    axi_lite_sram_slave #(.ADDR_BASE(BASE), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axi_lite_sram_slave #(.ADDR_BASE(BASE), .DEPTH_WORDS(1024), .LATENCY(0)) dut_z (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready_z),
        .rdata(rdata_z), .rresp(rresp_z), .rvalid(rvalid_z), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready_z),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_z),
        .bresp(bresp_z), .bvalid(bvalid_z), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < 32'd1024);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic push_read(input logic [31:0] a);
        if (in_range(a)) rq.push_back({2'b00, mdl[widx(a)]});
        else rq.push_back({2'b10, 32'd0});
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [7:0] s);
        if (in_range(a)) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) mdl[widx(a)][8*i +: 8] = d[8*i +: 8];
            bq.push_back(2'b00);
        end else begin
            bq.push_back(2'b10);
        end
    endtask

    task automatic rd(input logic [31:0] a, input int hold);
        int n;
        logic [33:0] exp;
        logic [31:0] d0;
        araddr = a; arvalid = 1; rready = (hold == 0);
        push_read(a);
        #1;
        n = 0;
        while (!arready && n < 40) begin @(posedge clk); #1; n++; end
        check("ar_accept", arready, 1);
        @(posedge clk); #1;
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 40) begin @(posedge clk); #1; n++; end
        check("r_latency", n, LAT);
        d0 = rdata;
        repeat (hold) begin
            @(posedge clk); #1;
            check("r_hold_valid", rvalid, 1);
            check("r_hold_data", rdata, d0);
        end
        rready = 1;
        exp = rq.pop_front();
        check("rdata", rdata, exp[31:0]);
        check("rresp", rresp, 32'(exp[33:32]));
        @(posedge clk); #1;
        check("r_done", rvalid, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [7:0] s);
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1; wvalid = 1; bready = 1;
        model_write(a, d, s);
        #1;
        n = 0;
        while (!awready && n < 40) begin @(posedge clk); #1; n++; end
        check("aw_accept", awready, 1);
        check("w_accept", wready, 1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 40) begin @(posedge clk); #1; n++; end
        check("b_latency", n, LAT);
        check("bresp", bresp, 32'(bq.pop_front()));
        @(posedge clk); #1;
        check("b_done", bvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [33:0] exp;
        for (int i = 0; i < 1024; i++) mdl[i] = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rresp", rresp, 0);
        check("rst_bresp", bresp, 0);
        rst = 1;
        #1;
        check("idle_arready", arready, 1);
        @(posedge clk); #1;

        wr(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F);
        rd(32'h8000_0010, 0);
        wr(32'h8000_0010, 32'h0000_AA00, 8'h02);
        rd(32'h8000_0010, 0);
        wr(32'h8000_0010, 32'hFFFF_FFFF, 8'hF0);
        rd(32'h8000_0010, 0);

        // simultaneous read and write: read first, write held pending
        araddr = 32'h8000_0010; arvalid = 1; rready = 1;
        awaddr = 32'h8000_0014; wdata = 32'h0102_0304; wstrb = 8'h0F;
        awvalid = 1; wvalid = 1; bready = 1;
        push_read(araddr);
        model_write(awaddr, wdata, wstrb);
        #1;
        check("both_arready", arready, 1);
        check("both_awready", awready, 0);
        @(posedge clk); #1;
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 40) begin
            check("aw_blocked", awready, 0);
            @(posedge clk); #1; n++;
        end
        check("both_r_latency", n, LAT);
        check("aw_blocked_resp", awready, 0);
        exp = rq.pop_front();
        check("both_rdata", rdata, exp[31:0]);
        @(posedge clk); #1;
        check("both_r_done", rvalid, 0);
        check("aw_after_read", awready, 1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 40) begin @(posedge clk); #1; n++; end
        check("both_b_latency", n, LAT);
        check("both_bresp", bresp, 32'(bq.pop_front()));
        @(posedge clk); #1;
        rd(32'h8000_0014, 0);

        rd(32'h8000_0010, 5);

        wr(32'h8000_0000, 32'hCAFE_0000, 8'h0F);
        rd(32'h7FFF_FFFC, 0);
        rd(32'h8000_1000, 0);
        wr(32'h8000_1000, 32'h1234_5678, 8'h0F);
        wr(32'h7FFF_FFFC, 32'h8765_4321, 8'h0F);
        rd(32'h8000_0000, 0);

        // reset while the write waits: it must never commit or respond
        wr(32'h8000_0020, 32'h1111_1111, 8'h0F);
        awaddr = 32'h8000_0020; wdata = 32'h2222_2222; wstrb = 8'h0F;
        awvalid = 1; wvalid = 1; bready = 1;
        #1;
        check("abort_awready", awready, 1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        rst = 0;
        #1;
        check("rst_forces_arready", arready, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_bvalid", bvalid, 0);
            check("abort_arready", arready, 0);
        end
        rst = 1;
        #1;
        check("post_rst_arready", arready, 1);
        check("post_rst_bvalid", bvalid, 0);
        rd(32'h8000_0020, 0);

        // zero-latency instance answers on the edge after the handshake
        araddr = 32'h8000_1000; arvalid = 1; rready = 1;
        #1;
        @(posedge clk); #1;
        arvalid = 0;
        check("z_rvalid", rvalid_z, 1);
        check("z_rresp", rresp_z, 2);
        check("z_rdata", rdata_z, 0);
        check("main_not_yet", rvalid, 0);
        @(posedge clk); #1;
        check("z_r_done", rvalid_z, 0);
        n = 1;
        while (!rvalid && n < 40) begin @(posedge clk); #1; n++; end
        check("main_r_latency", n, LAT);
        check("main_rresp", rresp, 2);
        @(posedge clk); #1;

        awaddr = 32'h8000_1000; wdata = 32'h5555_5555; wstrb = 8'h0F;
        awvalid = 1; wvalid = 1; bready = 1;
        #1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        check("z_bvalid", bvalid_z, 1);
        check("z_bresp", bresp_z, 2);
        @(posedge clk); #1;
        check("z_b_done", bvalid_z, 0);
        n = 1;
        while (!bvalid && n < 40) begin @(posedge clk); #1; n++; end
        check("main_b_latency", n, LAT);
        check("main_bresp", bresp, 2);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
